// File: rtl/pwm_peripheral.sv
// 16-channel PWM peripheral: a prescaler feeds an 8-bit period counter shared by all channels.
// Each channel is off, statically on, or follows the common PWM level; outputs are registered.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    duty_q, duty_d;
    logic [15:0]   out_q, out_d;
    logic          wrap_q;
    logic          period_start_q;

    logic          tick;
    logic          wrap;
    logic          pwm;
    logic [15:0]   en_out;
    logic [15:0]   en_pwm;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        wrap    = tick && (cnt_q == 8'hFF);
        presc_d = tick ? '0 : presc_q + PW'(1);
        cnt_d   = tick ? cnt_q + 8'd1 : cnt_q;
        // Duty is only sampled at the wrap so a running period is never altered.
        duty_d  = wrap ? pwm_duty_cycle : duty_q;
        pwm     = (duty_q == 8'hFF) || (cnt_q < duty_q);
        out_d   = en_out & (~en_pwm | {16{pwm}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            duty_q         <= '0;
            out_q          <= '0;
            wrap_q         <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            out_q          <= out_d;
            // Delayed twice so the pulse lines up with the first registered output of the period.
            wrap_q         <= wrap;
            period_start_q <= wrap_q;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 Parameter CLK_DIV, default 12, prescaler division ratio (legal range 1..4096); one PWM count tick every CLK_DIV clk cycles.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 en_reg_out_7_0  input  8  output enable, channels 7..0.
REQ-005 en_reg_out_15_8  input  8  output enable, channels 15..8.
REQ-006 en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0.
REQ-007 en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8.
REQ-008 pwm_duty_cycle  input  8  requested duty, 0x00 = 0 %, 0xFF = 100 %.
REQ-009 out  output  16  registered channel outputs, bit n = channel n.
REQ-010 period_start  output  1  one-clk pulse marking the first clk cycle of each PWM period.

Function
REQ-011 Prescaler: counter presc, 0..CLK_DIV-1, increments every clk, wraps to 0; tick = (presc == CLK_DIV-1); CLK_DIV = 1 gives tick every clk.
REQ-012 Period counter: 8-bit cnt, increments by 1 on tick, wraps 0xFF -> 0x00; period = 256 ticks = 256*CLK_DIV clk.
REQ-013 Shadow duty: 8-bit duty_q loads pwm_duty_cycle on the clk where tick and cnt == 0xFF (same edge cnt wraps to 0); no other load point, so mid-period duty changes never alter the running period.
REQ-014 PWM level: pwm = 1 when duty_q == 0xFF, else pwm = (cnt < duty_q); duty_q == 0x00 gives constant 0.
REQ-015 Channel n next value: en_out[n] = 0 -> 0; en_out[n] = 1 and en_pwm[n] = 0 -> 1; en_out[n] = 1 and en_pwm[n] = 1 -> pwm.
REQ-016 out registered: reflects enables, mode and pwm from the previous clk (1 clk latency); all PWM channels switch on the same clk edge.
REQ-017 Enable/mode changes take effect on the next clk edge, regardless of position in period (no shadowing of enables).
REQ-018 period_start = 1 for exactly one clk, the clk after cnt wraps 0xFF -> 0x00 (i.e. registered with out, first cycle outputs use new duty_q).
REQ-019 High time per period = duty_q * CLK_DIV clk for duty_q 0x00..0xFE, full period for 0xFF; no glitch or extra edge at wrap.
REQ-020 en_pwm[n] = 1 with en_out[n] = 0 SHALL give out[n] = 0 (enable dominates).

Reset
REQ-021 rst_n low: presc = 0, cnt = 0, duty_q = 0x00, out = 0x0000, period_start = 0, immediately and asynchronously.
REQ-022 After rst_n deassertion, counting starts at the next clk edge; first duty_q load occurs at end of first full period (outputs in PWM mode stay 0 until then).
REQ-023 Reset asserted mid-period aborts the period; no output held from before reset.

Verification
REQ-024 CLK_DIV=1, en_out=0xFFFF, en_pwm=0x0000 -> out=0xFFFF one clk after inputs applied; en_out=0x0000 -> out=0x0000.
REQ-025 CLK_DIV=1, en_out=en_pwm=0x0001, duty=0x80, wait one period -> out[0] high 128 clk, low 128 clk per 256-clk period, out[15:1]=0.
REQ-026 CLK_DIV=12, duty=0x40 on channel 5 -> high 768 clk per 3072-clk period; period_start pulses every 3072 clk.
REQ-027 Duty 0x00 -> out[n] constant 0; duty 0xFF -> constant 1 across wrap, no one-clk low glitch.
REQ-028 Change duty 0x20 -> 0xC0 at cnt=0x10 -> current period keeps 0x20 high time, next period (after period_start) uses 0xC0.
REQ-029 Assert rst_n low mid-period with out[0] high -> out=0x0000 asynchronously; after release, PWM channel stays 0 for first period.
